// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared types and mode constants for the SPI initiator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_master_state_t;

  localparam logic       c_cpol       = 1'b0;
  localparam logic       c_cpha       = 1'b0;
  localparam logic [1:0] c_spi_mode   = {c_cpol, c_cpha};
  localparam logic       c_msb_first  = 1'b1;
  localparam int         c_data_width = 8;

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// ============================================================================
// Module : spi_master_if
// Brief  : Byte stream handshake plus SPI pins of the initiator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spi_master_if import spi_pkg::*; #(
  parameter int DATA_WIDTH = c_data_width
) ();

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  sck;
  logic                  sdo;
  logic                  sdi;
  logic                  ce;

  modport master (
    input  tx_valid, tx_data, sdi,
    output tx_ready, rx_valid, rx_data, sck, sdo, ce
  );

  modport slave (
    output tx_valid, tx_data, sdi,
    input  tx_ready, rx_valid, rx_data, sck, sdo, ce
  );

endinterface

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ============================================================================
// Module : spi_sck_gen
// Brief  : Phase counter marking the end of each clk_div-cycle SCK half-period.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int              c_cw      = $clog2(CLK_DIV);
  localparam logic [c_cw-1:0] c_last    = c_cw'(CLK_DIV - 1);
  localparam logic [c_cw-1:0] c_prelast = c_cw'(CLK_DIV - 2);

  logic [c_cw-1:0] r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (!run || r_phase == c_last) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign tick     = run && (r_phase == c_last);
  assign pre_tick = run && (r_phase == c_prelast);

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module : spi_master
// Brief  : Mode-0 SPI initiator driven by a valid/ready byte stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_master import spi_pkg::*; #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = c_data_width
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_master_if.master    bus
);

  localparam int                c_cnt_w    = $clog2(DATA_WIDTH);
  localparam int                c_first    = c_msb_first ? DATA_WIDTH - 1 : 0;
  localparam logic              c_sck_idle = c_spi_mode[1];
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DATA_WIDTH - 1);

  spi_master_state_t       r_state;
  logic                    r_ce;
  logic                    r_sck;
  logic                    r_sdo;
  logic                    r_tx_ready;
  logic                    r_rx_valid;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-1:0]   r_rx_shift;
  logic [c_cnt_w-1:0]      r_bit_cnt;

  logic                    w_tick;
  logic                    w_pre_tick;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_tx_shifted;
  logic                    w_next_bit;
  logic [DATA_WIDTH-1:0]   w_rx_next;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (r_state != ST_IDLE),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  // tx_ready is only ever high in IDLE or the last TRAIL cycle, so it alone
  // qualifies an accept.
  assign w_accept     = bus.tx_valid & r_tx_ready;
  assign w_tx_shifted = c_msb_first ? (r_tx_shift << 1) : (r_tx_shift >> 1);
  assign w_next_bit   = c_msb_first ? r_tx_shift[DATA_WIDTH-2] : r_tx_shift[1];
  assign w_rx_next    = c_msb_first ? {r_rx_shift[DATA_WIDTH-2:0], bus.sdi}
                                    : {bus.sdi, r_rx_shift[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ce       <= 1'b0;
      r_sck      <= c_sck_idle;
      r_sdo      <= 1'b0;
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: ;
        ST_LEAD, ST_LOW: begin
          if (w_tick) begin
            r_sck   <= ~c_sck_idle;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_sck      <= c_sck_idle;
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt != '0) begin
              r_tx_shift <= w_tx_shifted;
              r_sdo      <= w_next_bit;
              r_bit_cnt  <= r_bit_cnt - 1'b1;
              r_state    <= ST_LOW;
            end else begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_state    <= ST_TRAIL;
            end
          end
        end
        ST_TRAIL: begin
          if (w_pre_tick) begin
            r_tx_ready <= 1'b1;
          end
          if (w_tick) begin
            r_tx_ready <= 1'b0;
            r_ce       <= 1'b0;
            r_sdo      <= 1'b0;
            r_state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_tx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // An accept (idle start or burst) overrides whatever the state did.
      if (w_accept) begin
        r_tx_shift <= bus.tx_data;
        r_sdo      <= bus.tx_data[c_first];
        r_bit_cnt  <= c_cnt_load;
        r_ce       <= 1'b1;
        r_tx_ready <= 1'b0;
        r_state    <= ST_LEAD;
      end
    end
  end

  assign bus.ce       = r_ce;
  assign bus.sck      = r_sck;
  assign bus.sdo      = r_sdo;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module : tb_spi_master
// Brief  : Randomized self-checking bench for spi_master (D=4 and D=2 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  logic       sel = 1'b0;
  logic       tv = 1'b0;
  logic       lb = 1'b1;
  logic [7:0] td = 8'h00;
  logic [7:0] p_tx = 8'h00;
  logic [7:0] p_shift = 8'h00;
  logic [7:0] p_rx = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  int         rise_q[$];
  int         rxv_q[$];
  logic [7:0] rxd_q[$];
  int         rdy_q[$];
  int         sck_hi, ce_hi, ce_first, ce_falls, sdo_bad;
  logic       prev_sck = 1'b0, prev_ce = 1'b0, prev_sdo = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if #(.DATA_WIDTH(8)) bus4 ();
  spi_master_if #(.DATA_WIDTH(8)) bus2 ();

  spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) dut4 (.clk(clk), .reset_n(rst_n), .bus(bus4.master));
  spi_master #(.CLK_DIV(2), .DATA_WIDTH(8)) dut2 (.clk(clk), .reset_n(rst_n), .bus(bus2.master));

  assign bus4.tx_valid = tv && !sel;
  assign bus4.tx_data  = td;
  assign bus4.sdi      = lb ? bus4.sdo : p_shift[7];
  assign bus2.tx_valid = tv && sel;
  assign bus2.tx_data  = td;
  assign bus2.sdi      = lb ? bus2.sdo : p_shift[7];

  logic       o_sck, o_ce, o_sdo, o_tx_ready, o_rx_valid;
  logic [7:0] o_rx_data;
  assign o_sck      = sel ? bus2.sck      : bus4.sck;
  assign o_ce       = sel ? bus2.ce       : bus4.ce;
  assign o_sdo      = sel ? bus2.sdo      : bus4.sdo;
  assign o_tx_ready = sel ? bus2.tx_ready : bus4.tx_ready;
  assign o_rx_valid = sel ? bus2.rx_valid : bus4.rx_valid;
  assign o_rx_data  = sel ? bus2.rx_data  : bus4.rx_data;

  // Peripheral: presents its byte on ce rise, shifts on sck fall, captures on rise.
  always @(posedge o_ce) p_shift = p_tx;
  always @(negedge o_sck) if (o_ce) p_shift = p_shift << 1;
  always @(posedge o_sck) p_rx = {p_rx[6:0], o_sdo};

  always @(negedge clk) begin
    if (o_sck && !prev_sck) rise_q.push_back(cyc);
    if (o_sck) sck_hi++;
    if (o_sck && (o_sdo !== prev_sdo)) sdo_bad++;
    if (o_rx_valid) begin
      rxv_q.push_back(cyc);
      rxd_q.push_back(o_rx_data);
    end
    if (o_ce) begin
      if (ce_hi == 0) ce_first = cyc;
      ce_hi++;
    end
    if (!o_ce && prev_ce) ce_falls++;
    if (o_tx_ready && o_ce) rdy_q.push_back(cyc);
    prev_sck = o_sck;
    prev_ce  = o_ce;
    prev_sdo = o_sdo;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete(); rxv_q.delete(); rxd_q.delete(); rdy_q.delete();
    sck_hi = 0; ce_hi = 0; ce_first = 0; ce_falls = 0; sdo_bad = 0;
  endtask

  // One frame (n=1) or a two-byte burst (n=2); expectations from the timing rules.
  task automatic xfer(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic loop, input logic [7:0] pb);
    int         d, t;
    int         c[2];
    logic [7:0] bs[2];
    d = sel ? 2 : 4;
    bs[0] = b0; bs[1] = b1;
    c[0] = 0; c[1] = 0;
    lb = loop; p_tx = pb;
    @(posedge clk); #1;
    clear_mon();
    tv = 1'b1; td = b0;
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!o_tx_ready && t < 500);
      if (!o_tx_ready) begin
        chk("accept_timeout", 32'd0, 32'd1);
        tv = 1'b0;
        return;
      end
      c[k] = cyc;
      @(posedge clk); #1;
      td = b1;
    end
    tv = 1'b0;
    if (n == 2) chk("burst_accept_gap", c[1] - c[0], 17 * d);
    while (cyc < c[n-1] + 18 * d) @(negedge clk);
    chk("gap_not_ready", o_tx_ready, 1'b0);
    chk("gap_ce_low", o_ce, 1'b0);
    @(negedge clk);
    chk("idle_ready", o_tx_ready, 1'b1);
    chk("idle_sck_low", o_sck, 1'b0);
    @(posedge clk); #1;
    chk("n_sck_rise", rise_q.size(), 8 * n);
    for (int i = 0; i < 8 * n; i++)
      chk("sck_rise_cycle", (i < rise_q.size()) ? rise_q[i] : -1, c[i/8] + d + 1 + 2 * d * (i % 8));
    chk("sck_high_cycles", sck_hi, 8 * n * d);
    chk("n_rx_valid", rxv_q.size(), n);
    for (int k = 0; k < n; k++) begin
      chk("rx_valid_cycle", (k < rxv_q.size()) ? rxv_q[k] : -1, c[k] + 16 * d + 1);
      chk("rx_data", (k < rxd_q.size()) ? {24'd0, rxd_q[k]} : 32'hFFFF_FFFF, loop ? bs[k] : pb);
    end
    chk("ce_first", ce_first, c[0] + 1);
    chk("ce_high_cycles", ce_hi, c[n-1] + 17 * d - c[0]);
    chk("ce_falls", ce_falls, 1);
    chk("n_ready_window", rdy_q.size(), n);
    for (int k = 0; k < n; k++)
      chk("ready_window_cycle", (k < rdy_q.size()) ? rdy_q[k] : -1, c[k] + 17 * d);
    chk("sdo_stable_while_sck_high", sdo_bad, 0);
    if (!loop) chk("periph_captured", p_rx, b0);
  endtask

  int         rn, t;
  logic [7:0] ra, rb, rp;
  logic       rl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", o_tx_ready, 1'b1);
    chk("rst_ce", o_ce, 1'b0);
    chk("rst_sck", o_sck, 1'b0);
    chk("rst_sdo", o_sdo, 1'b0);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_rx_data", o_rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(1, 8'hA5, 8'h00, 1'b1, 8'h00);

    // Reset after the third sck rise of a loopback byte.
    @(posedge clk); #1;
    clear_mon();
    lb = 1'b1; tv = 1'b1; td = 8'hE7;
    @(negedge clk);
    @(posedge clk); #1;
    tv = 1'b0;
    t = 0;
    while (rise_q.size() < 3 && t < 500) begin @(posedge clk); #1; t++; end
    chk("rst_mid_reached", (rise_q.size() >= 3) ? 1 : 0, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ce", o_ce, 1'b0);
    chk("async_rst_sck", o_sck, 1'b0);
    chk("async_rst_sdo", o_sdo, 1'b0);
    chk("async_rst_ready", o_tx_ready, 1'b1);
    chk("async_rst_rx_data", o_rx_data, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("no_rx_valid_after_rst", rxv_q.size(), 0);
    xfer(1, 8'h5A, 8'h00, 1'b1, 8'h00);

    xfer(1, 8'hC3, 8'h00, 1'b0, 8'h3C);
    xfer(2, 8'h12, 8'h34, 1'b1, 8'h00);

    repeat (4) begin
      rn = $urandom_range(1, 2);
      ra = 8'($urandom); rb = 8'($urandom); rp = 8'($urandom);
      rl = (rn == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      xfer(rn, ra, rb, rl, rp);
    end

    sel = 1'b1;
    xfer(1, 8'hFF, 8'h00, 1'b1, 8'h00);
    xfer(1, 8'h00, 8'h00, 1'b1, 8'h00);
    repeat (3) begin
      rn = $urandom_range(1, 2);
      ra = 8'($urandom); rb = 8'($urandom); rp = 8'($urandom);
      rl = (rn == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      xfer(rn, ra, rb, rl, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
